// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID/MEM/WB inputs and EX outputs of the operand stage
interface ex_operand_stage_if;
  logic        stall;
  logic        flush;
  logic [31:0] d_qa;
  logic [31:0] d_qb;
  logic [31:0] d_imm;
  logic [4:0]  d_sa;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [4:0]  d_rn;
  logic        d_use_rs;
  logic        d_use_rt;
  logic [3:0]  d_aluc;
  logic        d_aluimm;
  logic        d_shift;
  logic        d_wreg;
  logic        d_m2reg;
  logic        d_wmem;
  logic [4:0]  m_rn;
  logic        m_wreg;
  logic        m_m2reg;
  logic [31:0] m_alu;
  logic [4:0]  w_rn;
  logic        w_wreg;
  logic [31:0] w_data;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [3:0]  e_aluc;
  logic [31:0] e_sd;
  logic [4:0]  e_rn;
  logic        e_wreg;
  logic        e_m2reg;
  logic        e_wmem;
  logic        lu_stall;

  modport master (
    output stall, flush, d_qa, d_qb, d_imm, d_sa, d_rs, d_rt, d_rn,
           d_use_rs, d_use_rt, d_aluc, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem,
           m_rn, m_wreg, m_m2reg, m_alu, w_rn, w_wreg, w_data,
    input  e_a, e_b, e_aluc, e_sd, e_rn, e_wreg, e_m2reg, e_wmem, lu_stall
  );

  modport slave (
    input  stall, flush, d_qa, d_qb, d_imm, d_sa, d_rs, d_rt, d_rn,
           d_use_rs, d_use_rt, d_aluc, d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem,
           m_rn, m_wreg, m_m2reg, m_alu, w_rn, w_wreg, w_data,
    output e_a, e_b, e_aluc, e_sd, e_rn, e_wreg, e_m2reg, e_wmem, lu_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - EX pipeline register with operand forwarding and load-use interlock
module ex_operand_stage (
  input logic           clock,
  input logic           resetn,
  ex_operand_stage_if.slave bus
);

  logic [31:0] qa, qb, imm;
  logic [4:0]  sa, rs, rt, rn;
  logic [3:0]  aluc;
  logic        aluimm, shift, wreg, m2reg, wmem;
  logic        lu_stall;
  logic [31:0] fwd_a, fwd_b;

  // A load in EX cannot supply its data until MEM completes, so a dependent ID op must wait.
  assign lu_stall = m2reg && (rn != 5'd0) &&
                    ((bus.d_use_rs && (bus.d_rs == rn)) || (bus.d_use_rt && (bus.d_rt == rn)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      qa <= '0; qb <= '0; imm <= '0; sa <= '0; rs <= '0; rt <= '0; rn <= '0;
      aluc <= '0; aluimm <= 1'b0; shift <= 1'b0;
      wreg <= 1'b0; m2reg <= 1'b0; wmem <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.flush || lu_stall) begin
        qa <= '0; qb <= '0; imm <= '0; sa <= '0; rs <= '0; rt <= '0; rn <= '0;
        aluc <= '0; aluimm <= 1'b0; shift <= 1'b0;
        wreg <= 1'b0; m2reg <= 1'b0; wmem <= 1'b0;
      end else begin
        qa <= bus.d_qa; qb <= bus.d_qb; imm <= bus.d_imm; sa <= bus.d_sa;
        rs <= bus.d_rs; rt <= bus.d_rt; rn <= bus.d_rn;
        aluc <= bus.d_aluc; aluimm <= bus.d_aluimm; shift <= bus.d_shift;
        wreg <= bus.d_wreg; m2reg <= bus.d_m2reg; wmem <= bus.d_wmem;
      end
    end
  end

  // MEM wins over WB; loaded values in MEM are never forwarded, the interlock covers them.
  always_comb begin
    fwd_a = qa;
    if (bus.m_wreg && !bus.m_m2reg && (bus.m_rn != 5'd0) && (bus.m_rn == rs))
      fwd_a = bus.m_alu;
    else if (bus.w_wreg && (bus.w_rn != 5'd0) && (bus.w_rn == rs))
      fwd_a = bus.w_data;
  end

  always_comb begin
    fwd_b = qb;
    if (bus.m_wreg && !bus.m_m2reg && (bus.m_rn != 5'd0) && (bus.m_rn == rt))
      fwd_b = bus.m_alu;
    else if (bus.w_wreg && (bus.w_rn != 5'd0) && (bus.w_rn == rt))
      fwd_b = bus.w_data;
  end

  assign bus.e_a      = shift ? {27'b0, sa} : fwd_a;
  assign bus.e_b      = aluimm ? imm : fwd_b;
  assign bus.e_sd     = fwd_b;
  assign bus.e_aluc   = aluc;
  assign bus.e_rn     = rn;
  assign bus.e_wreg   = wreg;
  assign bus.e_m2reg  = m2reg;
  assign bus.e_wmem   = wmem;
  assign bus.lu_stall = lu_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    bus.stall = 0; bus.flush = 0;
    bus.d_qa = 0; bus.d_qb = 0; bus.d_imm = 0; bus.d_sa = 0;
    bus.d_rs = 0; bus.d_rt = 0; bus.d_rn = 0; bus.d_use_rs = 0; bus.d_use_rt = 0;
    bus.d_aluc = 0; bus.d_aluimm = 0; bus.d_shift = 0;
    bus.d_wreg = 0; bus.d_m2reg = 0; bus.d_wmem = 0;
    bus.m_rn = 0; bus.m_wreg = 0; bus.m_m2reg = 0; bus.m_alu = 0;
    bus.w_rn = 0; bus.w_wreg = 0; bus.w_data = 0;

    // reset state before any clock edge
    #3;
    check("rst_e_aluc", 32'(bus.e_aluc), 32'h0);
    check("rst_e_rn", 32'(bus.e_rn), 32'h0);
    check("rst_ctrl", {29'b0, bus.e_wreg, bus.e_m2reg, bus.e_wmem}, 32'h0);
    check("rst_e_sd", bus.e_sd, 32'h0);
    check("rst_lu_stall", 32'(bus.lu_stall), 32'h0);
    check("rst_e_a", bus.e_a, 32'h0);
    check("rst_e_b", bus.e_b, 32'h0);
    tick();
    resetn = 1'b1;

    // basic load, no hazards
    bus.d_qa = 32'd5; bus.d_qb = 32'd7; bus.d_rs = 5'd1; bus.d_rt = 5'd2; bus.d_aluc = 4'b0000;
    tick();
    check("basic_e_a", bus.e_a, 32'd5);
    check("basic_e_b", bus.e_b, 32'd7);
    check("basic_e_aluc", 32'(bus.e_aluc), 32'h0);
    check("basic_e_sd", bus.e_sd, 32'd7);

    // forwarding priority MEM > WB > register
    bus.d_rs = 5'd3; bus.d_rt = 5'd3; bus.d_qa = 32'd1; bus.d_qb = 32'd2;
    bus.m_rn = 5'd3; bus.m_wreg = 1; bus.m_m2reg = 0; bus.m_alu = 32'hAA;
    bus.w_rn = 5'd3; bus.w_wreg = 1; bus.w_data = 32'hBB;
    tick();
    check("fwd_mem_e_a", bus.e_a, 32'hAA);
    check("fwd_mem_e_b", bus.e_b, 32'hAA);
    check("fwd_mem_e_sd", bus.e_sd, 32'hAA);
    bus.m_m2reg = 1; #1;
    check("fwd_mem_load_excluded_e_a", bus.e_a, 32'hBB);
    bus.m_m2reg = 0; bus.m_wreg = 0; #1;
    check("fwd_wb_e_a", bus.e_a, 32'hBB);
    check("fwd_wb_e_b", bus.e_b, 32'hBB);
    bus.w_wreg = 0; #1;
    check("fwd_none_e_a", bus.e_a, 32'd1);
    check("fwd_none_e_b", bus.e_b, 32'd2);

    // shift amount and immediate selection
    bus.d_shift = 1; bus.d_sa = 5'd31; bus.d_qa = 32'hFFFFFFFF;
    bus.d_aluimm = 1; bus.d_imm = 32'h1234; bus.d_qb = 32'h5555;
    bus.d_aluc = 4'b1010; bus.d_rn = 5'd9; bus.d_wreg = 1;
    tick();
    check("shift_e_a", bus.e_a, 32'h0000001F);
    check("imm_e_b", bus.e_b, 32'h1234);
    check("imm_e_sd", bus.e_sd, 32'h5555);
    check("imm_e_aluc", 32'(bus.e_aluc), 32'hA);
    check("imm_e_rn", 32'(bus.e_rn), 32'd9);
    check("imm_e_wreg", 32'(bus.e_wreg), 32'd1);

    // load-use hazard
    bus.d_shift = 0; bus.d_aluimm = 0; bus.d_m2reg = 1; bus.d_wreg = 1; bus.d_rn = 5'd4;
    bus.d_rs = 5'd2; bus.d_rt = 5'd2;
    tick();
    check("lw_e_m2reg", 32'(bus.e_m2reg), 32'd1);
    check("lw_e_rn", 32'(bus.e_rn), 32'd4);
    bus.d_m2reg = 0; bus.d_rn = 5'd6; bus.d_rs = 5'd4; bus.d_use_rs = 0; #1;
    check("lu_no_use", 32'(bus.lu_stall), 32'd0);
    bus.d_use_rs = 1; #1;
    check("lu_rs", 32'(bus.lu_stall), 32'd1);
    bus.d_use_rs = 0; bus.d_rt = 5'd4; bus.d_use_rt = 1; #1;
    check("lu_rt", 32'(bus.lu_stall), 32'd1);
    bus.stall = 1;
    tick();
    check("lu_stall_hold_e_rn", 32'(bus.e_rn), 32'd4);
    check("lu_stall_hold_m2reg", 32'(bus.e_m2reg), 32'd1);
    check("lu_during_stall", 32'(bus.lu_stall), 32'd1);
    bus.stall = 0;
    tick();
    check("lu_bubble_ctrl", {29'b0, bus.e_wreg, bus.e_m2reg, bus.e_wmem}, 32'h0);
    check("lu_bubble_e_rn", 32'(bus.e_rn), 32'd0);
    check("lu_cleared", 32'(bus.lu_stall), 32'd0);

    // load to r0 never interlocks
    bus.d_use_rs = 0; bus.d_use_rt = 0; bus.d_m2reg = 1; bus.d_rn = 5'd0;
    tick();
    bus.d_m2reg = 0; bus.d_rs = 5'd0; bus.d_use_rs = 1; #1;
    check("lu_r0", 32'(bus.lu_stall), 32'd0);
    bus.d_use_rs = 0;

    // stall beats flush; flush alone inserts a bubble
    bus.d_aluc = 4'd5; bus.d_rn = 5'd7; bus.d_wreg = 1; bus.d_wmem = 1;
    tick();
    check("prio_load_e_rn", 32'(bus.e_rn), 32'd7);
    bus.d_rn = 5'd8; bus.d_aluc = 4'd6; bus.stall = 1; bus.flush = 1;
    tick();
    check("prio_stall_e_rn", 32'(bus.e_rn), 32'd7);
    check("prio_stall_e_aluc", 32'(bus.e_aluc), 32'd5);
    check("prio_stall_e_wmem", 32'(bus.e_wmem), 32'd1);
    bus.stall = 0;
    tick();
    check("prio_flush_e_rn", 32'(bus.e_rn), 32'd0);
    check("prio_flush_e_aluc", 32'(bus.e_aluc), 32'd0);
    check("prio_flush_ctrl", {29'b0, bus.e_wreg, bus.e_m2reg, bus.e_wmem}, 32'h0);
    bus.flush = 0;

    // r0 forwarding suppressed, then asynchronous reset between edges
    bus.d_rn = 5'd10; bus.d_aluc = 4'd3; bus.d_wreg = 1; bus.d_wmem = 0;
    bus.d_qa = 32'h11; bus.d_qb = 32'h22; bus.d_rs = 5'd0; bus.d_rt = 5'd0;
    tick();
    bus.m_rn = 5'd0; bus.m_wreg = 1; bus.m_alu = 32'hDEAD;
    bus.w_rn = 5'd0; bus.w_wreg = 1; bus.w_data = 32'hBEEF; #1;
    check("r0_no_fwd_e_a", bus.e_a, 32'h11);
    check("r0_no_fwd_e_b", bus.e_b, 32'h22);
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_e_rn", 32'(bus.e_rn), 32'd0);
    check("async_rst_e_aluc", 32'(bus.e_aluc), 32'd0);
    check("async_rst_e_wreg", 32'(bus.e_wreg), 32'd0);
    check("async_rst_e_a", bus.e_a, 32'd0);
    check("async_rst_e_sd", bus.e_sd, 32'd0);
    bus.stall = 1;
    tick();
    resetn = 1'b1;
    tick();
    check("rst_stall_hold_e_rn", 32'(bus.e_rn), 32'd0);
    bus.stall = 0;
    tick();
    check("rst_release_load_e_rn", 32'(bus.e_rn), 32'd10);
    check("rst_release_load_e_aluc", 32'(bus.e_aluc), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 No parameters; single clock domain; reset asynchronous, active-low.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 stall  in  1  global pipeline freeze; EX register holds.
REQ-005 flush  in  1  branch/jump kill; EX register loads bubble.
REQ-006 d_qa, d_qb  in  32 each  register-file read data for rs, rt.
REQ-007 d_imm  in  32  extended immediate; d_sa  in  5  shift amount.
REQ-008 d_rs, d_rt, d_rn  in  5 each  source/destination register numbers.
REQ-009 d_use_rs, d_use_rt  in  1 each  ID instruction reads rs/rt.
REQ-010 d_aluc  in  4  ALU op; d_aluimm, d_shift  in  1 each  operand-select controls.
REQ-011 d_wreg, d_m2reg, d_wmem  in  1 each  write-reg, load, store controls.
REQ-012 m_rn  in  5; m_wreg, m_m2reg  in  1 each; m_alu  in  32  MEM-stage forwarding source.
REQ-013 w_rn  in  5; w_wreg  in  1; w_data  in  32  WB-stage forwarding source.
REQ-014 e_a, e_b  out  32 each  ALU operands; e_aluc  out  4  ALU op.
REQ-015 e_sd  out  32  forwarded store data; e_rn  out  5.
REQ-016 e_wreg, e_m2reg, e_wmem  out  1 each  registered controls.
REQ-017 lu_stall  out  1  load-use hazard; upstream holds PC and IF/ID.

Function
REQ-018 EX register fields: qa, qb, imm, sa, rs, rt, rn, aluc, aluimm, shift, wreg, m2reg, wmem.
REQ-019 Update priority per rising edge: stall (hold all) > flush or lu_stall (load bubble) > load d_* fields.
REQ-020 Bubble: all fields zero (aluc=4'b0000, wreg=m2reg=wmem=0).
REQ-021 lu_stall combinational = e_m2reg & (e_rn!=0) & ((d_use_rs & d_rs==e_rn) | (d_use_rt & d_rt==e_rn)).
REQ-022 lu_stall ignores stall; during stall the EX register holds regardless of lu_stall.
REQ-023 fwd_a: MEM source if m_wreg & !m_m2reg & m_rn!=0 & m_rn==rs; else WB source if w_wreg & w_rn!=0 & w_rn==rs; else qa.
REQ-024 fwd_b: same rule using rt/qb; MEM source has priority over WB when both match.
REQ-025 Register 0 never forwarded; reads of r0 return the registered qa/qb.
REQ-026 e_a = {27'b0, sa} when shift=1, else fwd_a (full 32-bit zero-extended shift amount).
REQ-027 e_b = imm when aluimm=1, else fwd_b; e_sd = fwd_b always.
REQ-028 e_aluc, e_rn, e_wreg, e_m2reg, e_wmem driven directly from the EX register.
REQ-029 Latency: d_* sampled at edge N appear on e_* after edge N; forwarding muxes combinational in EX.
REQ-030 Forwarding from a load in MEM (m_m2reg=1) excluded; load-use interlock guarantees correctness.

Reset
REQ-031 resetn=0 clears the EX register to bubble immediately, independent of clock.
REQ-032 While resetn=0: e_aluc=0, e_rn=0, e_wreg=e_m2reg=e_wmem=0, e_sd=0, lu_stall=0.
REQ-033 e_a/e_b after reset follow forwarding rules with rs=rt=0, i.e. 0.
REQ-034 Reset deasserted mid-stall: first edge with stall=0 loads d_* normally.

Verification
REQ-035 d_qa=5, d_qb=7, aluc=0000, no hazards, one edge -> e_a=5, e_b=7, e_aluc=0000.
REQ-036 Forward: rs=rt=3; m_rn=3, m_wreg=1, m_alu=0xAA; w_rn=3, w_wreg=1, w_data=0xBB -> e_a=e_b=0xAA; m_wreg=0 -> 0xBB.
REQ-037 EX holds lw r4 (e_m2reg=1, e_rn=4); ID d_rs=4, d_use_rs=1 -> lu_stall=1; next edge EX=bubble, e_wreg=0.
REQ-038 Shift/imm: d_shift=1, d_sa=31, d_qa=0xFFFFFFFF -> e_a=0x0000001F; d_aluimm=1, d_imm=0x1234 -> e_b=0x1234.
REQ-039 Priority: stall=1 with flush=1 -> EX unchanged; stall=0, flush=1 -> bubble next edge.
REQ-040 Async reset: assert resetn=0 between edges -> outputs cleared without clock edge; r0 forwarding suppressed (m_rn=0, m_wreg=1 -> no forward).
